// File: rtl/signed_seq_divider.sv
// signed_seq_divider
// Sequential signed divider: one restoring step per clock on operand
// magnitudes, then a sign-fixup cycle. Quotient truncates toward zero and the
// remainder takes the dividend's sign.
//
// Optional feature macro: DIV_BY_ZERO_DETECT_EN
//   defined   : B == 0 at start skips the iteration and reports div_by_zero
//   undefined : B == 0 runs the normal algorithm, div_by_zero tied low
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   request, accepted in IDLE or DONE; A/B sampled then
//   A, B        in   signed dividend / divisor (WIDTH bits)
//   Q, R        out  registered signed quotient / remainder
//   busy        out  high in CALC and FIX
//   done        out  one-cycle pulse, Q/R/div_by_zero valid
//   div_by_zero out  zero-divisor flag, valid with done
//
// state | meaning
// IDLE  | waiting for start
// CALC  | WIDTH restoring iterations on magnitudes
// FIX   | apply signs, load Q/R
// DONE  | result valid, done high; start may chain a new operation
module signed_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic           sign_a, sign_b;
    logic           accept;
    logic           b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0] shifted, trial;

    assign accept = start && (state == IDLE || state == DONE);
    // Unsigned WIDTH-bit magnitudes: |most-negative| = 2^(WIDTH-1) fits exactly.
    assign mag_a  = A[WIDTH-1] ? -A : A;
    assign mag_b  = B[WIDTH-1] ? -B : B;
    assign b_zero = (B == '0);

    // quo holds the not-yet-consumed dividend bits; its MSB feeds the remainder.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
`ifdef DIV_BY_ZERO_DETECT_EN
                    state_nxt = b_zero ? FIX : CALC;
`else
                    state_nxt = CALC;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DIV_BY_ZERO_DETECT_EN
    logic zero_pend;
    logic dbz;
    assign div_by_zero = dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            Q      <= '0;
            R      <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
            zero_pend <= 1'b0;
            dbz       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                quo    <= mag_a;
                dvs    <= mag_b;
                rem    <= '0;
                sign_a <= A[WIDTH-1];
                sign_b <= B[WIDTH-1];
                cnt    <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
                zero_pend <= b_zero;
`endif
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                // trial[WIDTH] set means the subtraction went negative: restore.
                rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            end else if (state == FIX) begin
`ifdef DIV_BY_ZERO_DETECT_EN
                if (zero_pend) begin
                    // quo still holds |A| because CALC was skipped.
                    Q   <= '1;
                    R   <= sign_a ? -quo : quo;
                    dbz <= 1'b1;
                end else begin
                    Q   <= (sign_a ^ sign_b) ? -quo : quo;
                    R   <= sign_a ? -rem : rem;
                    dbz <= 1'b0;
                end
`else
                Q <= (sign_a ^ sign_b) ? -quo : quo;
                R <= sign_a ? -rem : rem;
`endif
            end
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Testbench for signed_seq_divider (WIDTH = 32). Timing convention: the edge
// accepting start is edge 0; "done at edge k" means done is seen high just
// before rising edge k (sampled on the falling edge).
module tb_signed_seq_divider;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  A, B;
    logic [W-1:0]  Q, R;
    logic          busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    signed_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on wide signed values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z   = 1'b0;
        lat = W + 2;
        if (b == 0) begin
            r = a;
`ifdef DIV_BY_ZERO_DETECT_EN
            q   = '1;
            z   = 1'b1;
            lat = 2;
`else
            q = (sa >= 0) ? '1 : W'(1);
`endif
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endtask

    // Called right after the accepting edge; returns at the falling edge where
    // done is seen (or after the time budget).
    task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int inj_k, input string tag);
        logic [W-1:0] eq, er, q0, r0;
        logic ez, z0;
        int el, k;
        bit busy_bad, hold_bad;
        model(a, b, eq, er, ez, el);
        busy_bad = 0;
        hold_bad = 0;
        q0 = '0; r0 = '0; z0 = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                q0 = Q; r0 = R; z0 = div_by_zero;
            end
            if (inj_k != 0 && k == inj_k) begin
                start = 1'b1; A = 9; B = 3;
            end
            if (inj_k != 0 && k == inj_k + 1) start = 1'b0;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_bad = 1;
            if (Q !== q0 || R !== r0 || div_by_zero !== z0) hold_bad = 1;
        end
        chk({tag, "_lat"}, 64'(k), 64'(el));
        chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
        chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_q"}, 64'(Q), 64'(eq));
        chk({tag, "_r"}, 64'(R), 64'(er));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit chain, input int inj_k, input string tag);
        if (!chain) begin
            @(negedge clk);
            chk({tag, "_pulse"}, 64'(done), 64'd0);
        end
        start = 1'b1; A = a; B = b;
        @(posedge clk);
        wait_result(a, b, inj_k, tag);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        bit no_done;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q", 64'(Q), 64'd0);
        chk("rst_r", 64'(R), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        op(32'd100, 32'd7, 0, 0, "d100_7");
        op(-32'd100, 32'd7, 0, 0, "dm100_7");
        op(32'd100, -32'd7, 0, 0, "d100_m7");
        op(-32'd100, -32'd7, 0, 0, "dm100_m7");
        op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "mneg_m1");
        op(-32'd1500, 32'd10, 0, 0, "dm1500_10");
        op(32'd42, 32'd0, 0, 0, "d42_0");
        op(-32'd42, 32'd0, 0, 0, "dm42_0");

        // start during CALC ignored, then start in the DONE cycle chains.
        op(32'd100, 32'd7, 0, 10, "ignore");
        op(32'd9, 32'd3, 1, 0, "chain");

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; A = 32'd100; B = 32'd7;
        @(posedge clk);
        for (int k = 1; k < 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_q", 64'(Q), 64'd0);
        chk("midrst_r", 64'(R), 64'd0);
        no_done = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 0;
        end
        chk("midrst_quiet", 64'(no_done), 64'd1);
        op(32'd100, 32'd7, 0, 0, "post_rst");

        for (int i = 0; i < 150; i++) begin
            op(pick(), pick(), 1'($urandom_range(0, 1)), 0, "rnd");
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_seq_divider.md
SIGNED_SEQ_DIVIDER -- requirements
Module: signed_seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (WIDTH >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; A and B are sampled on the edge where start is accepted.
REQ-005 SHALL have port A  input  WIDTH  signed dividend.
REQ-006 SHALL have port B  input  WIDTH  signed divisor.
REQ-007 SHALL have port Q  output  WIDTH  signed quotient, registered.
REQ-008 SHALL have port R  output  WIDTH  signed remainder, registered.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking Q/R/div_by_zero valid.
REQ-011 SHALL have port div_by_zero  output  1  zero-divisor flag, valid with done.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in CALC or FIX SHALL be ignored, with no effect on the operation in progress.
REQ-014 On acceptance SHALL latch the magnitudes |A| and |B| and both sign bits, clear the iteration counter, and go to CALC.
REQ-015 In CALC SHALL do one restoring step per cycle (shift the partial remainder left by one bit, trial-subtract |B|, commit if non-negative, set quotient bit), for exactly WIDTH cycles, then go to FIX.
REQ-016 In FIX SHALL negate the quotient if sign(A) != sign(B), negate the remainder if A < 0, load Q/R, and go to DONE.
REQ-017 Quotient SHALL truncate toward zero; remainder sign SHALL equal the dividend sign; A == Q*B + R SHALL hold modulo 2^WIDTH.
REQ-018 Most-negative / -1 SHALL yield Q = most-negative (wraps), R = 0, with no error flag.
REQ-019 Magnitudes SHALL be computed on WIDTH bits as unsigned, so |most-negative| is represented exactly.
REQ-020 done SHALL go high exactly WIDTH+2 rising edges after the edge that accepts start, and SHALL stay high for one cycle unless start is accepted again in that cycle.
REQ-021 busy SHALL be high in CALC and FIX, and low in IDLE and DONE.
REQ-022 Q, R and div_by_zero SHALL hold their values from the DONE state until the next FIX load or reset; they SHALL NOT change during CALC.
REQ-023 Start accepted in the DONE cycle SHALL begin a new operation, with no idle gap.

Reset
REQ-024 rst high on a clock edge SHALL force IDLE, Q=0, R=0, busy=0, done=0, div_by_zero=0, and clear internal state; this SHALL take priority over start and apply mid-operation.
REQ-025 After rst deasserts, the first accepted start SHALL behave per REQ-020.

Configuration
REQ-026 Macro DIV_BY_ZERO_DETECT_EN SHALL control early zero-divisor handling.
REQ-027 With DIV_BY_ZERO_DETECT_EN defined and B == 0 at acceptance, the block SHALL skip CALC and go to FIX, with done 2 edges after acceptance, Q = all ones, R = A, and div_by_zero = 1.
REQ-028 Without DIV_BY_ZERO_DETECT_EN:
- B == 0 SHALL run the full WIDTH-cycle algorithm.
- The result SHALL be Q = -1 for A >= 0, Q = 1 for A < 0, and R = A.
- div_by_zero SHALL be tied 0.

Verification (WIDTH=32)
REQ-029 A=100, B=7, start -> done at edge 34: Q=14, R=2, div_by_zero=0; busy high for edges 1-33.
REQ-030 Sign cases:
- A=-100, B=7 -> Q=-14, R=-2.
- A=100, B=-7 -> Q=-14, R=2.
- A=-100, B=-7 -> Q=14, R=-2.
REQ-031 A=0x80000000, B=-1 -> Q=0x80000000, R=0; A=-1500, B=10 -> Q=-150, R=0.
REQ-032 A=42, B=0:
- Macro defined -> done at edge 2, Q=0xFFFFFFFF, R=42, div_by_zero=1.
- Macro undefined -> done at edge 34, Q=0xFFFFFFFF, R=42, div_by_zero=0.
REQ-033 Start with A=9, B=3 pulsed at edge 10 of an active 100/7 operation -> ignored, result Q=14, R=2; start in the DONE cycle with A=9, B=3 -> next done 34 edges later, Q=3, R=0.
REQ-034 rst asserted at edge 15 of an operation -> next edge shows IDLE, busy=0, done=0, Q=0, R=0, and no done pulse follows.
